ps2_rx_frame: RTL and testbench

- PS/2 device-to-host frame receiver. Sits on the same ps2_clk/ps2_data lines as the host-to-device command sender, downstream of the mouse.
- Captures the ACK byte (0xFA) and the movement/status bytes that follow a command.
- Delivers each validated byte with a one-cycle strobe, and reports parity, framing and inter-bit timeout errors.
- Consumer: the mouse packet/command sequencer. The sequencer deasserts rx_enable while the sender drives the bus.

---
 rtl/ps2_rx_frame.sv | 151 +++++++++++++++
 tb/tb_ps2_rx_frame.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: filtered clock, start/8 data/odd parity/stop capture.
// Optional saturating error counter enabled with `define PS2_RX_ERRCNT_EN.
module ps2_rx_frame #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 32000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err_parity,
    output logic       rx_err_frame,
    output logic       rx_err_timeout,
    output logic       busy
`ifdef PS2_RX_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          clk_f, clk_f_d, fall;
    logic [FW-1:0] flt_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;

    // Two-flop synchronizers; lines idle high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Glitch filter: clk_f follows only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_f   <= 1'b1;
            flt_cnt <= '0;
            clk_f_d <= 1'b1;
            fall    <= 1'b0;
        end else begin
            if (clk_s2 == clk_f) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_f   <= clk_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
            clk_f_d <= clk_f;
            fall    <= clk_f_d & ~clk_f;
        end
    end

    // Frame FSM; priority is disable, then timeout, then sample event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            tmo_cnt        <= '0;
            shreg          <= '0;
            par            <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            rx_err_parity  <= 1'b0;
            rx_err_frame   <= 1'b0;
            rx_err_timeout <= 1'b0;
            busy           <= 1'b0;
        end else begin
            rx_valid       <= 1'b0;
            rx_err_parity  <= 1'b0;
            rx_err_frame   <= 1'b0;
            rx_err_timeout <= 1'b0;
            if (!rx_enable) begin
                state   <= IDLE;
                bit_cnt <= '0;
                tmo_cnt <= '0;
                busy    <= 1'b0;
            end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state          <= IDLE;
                bit_cnt        <= '0;
                tmo_cnt        <= '0;
                busy           <= 1'b0;
                rx_err_timeout <= 1'b1;
            end else begin
                tmo_cnt <= (fall || state == IDLE) ? '0 : tmo_cnt + TW'(1);
                if (fall) begin
                    case (state)
                        IDLE: begin
                            if (!data_s2) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                                busy    <= 1'b1;
                            end
                        end
                        DATA: begin
                            shreg   <= {data_s2, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= PARITY;
                        end
                        PARITY: begin
                            par   <= data_s2;
                            state <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!data_s2)                 rx_err_frame  <= 1'b1;
                            else if (^{shreg, par} != 1'b1) rx_err_parity <= 1'b1;
                            else begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

`ifdef PS2_RX_ERRCNT_EN
    // Saturating count of error pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if ((rx_err_parity | rx_err_frame | rx_err_timeout) && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: frame-level reference model, directed plus random frames.
module tb_ps2_rx_frame;
    localparam int unsigned FLT = 8;
    localparam int unsigned TMO = 600;
    localparam int unsigned HP  = 50;

    logic       clk = 1'b0;
    logic       reset, rx_enable, ps2_clk, ps2_data;
    logic [7:0] rx_data;
    logic       rx_valid, rx_err_parity, rx_err_frame, rx_err_timeout, busy;
`ifdef PS2_RX_ERRCNT_EN
    logic [7:0] err_count;
`endif

    ps2_rx_frame #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rx_enable(rx_enable),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err_parity(rx_err_parity),
        .rx_err_frame(rx_err_frame), .rx_err_timeout(rx_err_timeout), .busy(busy)
`ifdef PS2_RX_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 good byte, 1 parity error, 2 frame error, 3 timeout
    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned last_fall = 0;
    logic [7:0]  model_last_good = 8'h00;
    int          model_errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Device changes data while clock is high; host samples on the falling edge
    task automatic clock_bit(input logic b);
        ps2_data = b;
        wait_cycles(HP);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        wait_cycles(HP);
        ps2_clk = 1'b1;
    endtask

    task automatic glitch();
        ps2_clk = 1'b0;
        wait_cycles(3);
        ps2_clk = 1'b1;
    endtask

    function automatic exp_t model(input logic [7:0] d, input logic p, input logic s);
        exp_t e;
        if (!s) begin
            e.kind = 2;
            e.data = model_last_good;
        end else if ((($countones(d) + int'(p)) % 2) == 0) begin
            e.kind = 1;
            e.data = model_last_good;
        end else begin
            e.kind = 0;
            e.data = d;
        end
        return e;
    endfunction

    task automatic push_exp(input exp_t e);
        if (e.kind == 0) model_last_good = e.data;
        else             model_errs++;
        q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int glitch_after);
        push_exp(model(d, p, s));
        clock_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            clock_bit(d[i]);
            if (i == 3) check("busy_mid_frame", 32'(busy), 32'd1);
            if (i == glitch_after) begin
                wait_cycles(20);
                glitch();
            end
        end
        clock_bit(p);
        clock_bit(s);
        ps2_data = 1'b1;
        wait_cycles(2 * HP);
    endtask

    // Scoreboard monitor: pops one expectation per output strobe
    initial begin
        exp_t e;
        int   kind;
        forever begin
            @(negedge clk);
            if (reset && (rx_valid | rx_err_parity | rx_err_frame | rx_err_timeout)) begin
                check("one_strobe", 32'($countones({rx_valid, rx_err_parity, rx_err_frame, rx_err_timeout})), 32'd1);
                kind = rx_valid ? 0 : rx_err_parity ? 1 : rx_err_frame ? 2 : 3;
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got kind %0d with nothing expected (cycle %0d)", kind, cyc);
                end else begin
                    e = q.pop_front();
                    check("strobe_kind", 32'(kind), 32'(e.kind));
                    check("rx_data", 32'(rx_data), 32'(e.data));
                    check("busy_at_strobe", 32'(busy), 32'd0);
                    if (e.kind == 3) begin
                        n_checks++;
                        if (cyc - last_fall < TMO || cyc - last_fall > TMO + FLT + 10) begin
                            n_fail++;
                            $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d", cyc - last_fall, TMO, TMO + FLT + 10);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        rx_enable = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        wait_cycles(3);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_flags", 32'({rx_valid, rx_err_parity, rx_err_frame, rx_err_timeout}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
`ifdef PS2_RX_ERRCNT_EN
        check("reset_err_count", 32'(err_count), 32'd0);
`endif
        reset = 1'b1;
        wait_cycles(20);

        send_frame(8'hFA, 1'b1, 1'b1, -1);
        check("busy_after_fa", 32'(busy), 32'd0);
        send_frame(8'h00, 1'b0, 1'b1, -1);
        send_frame(8'hAA, 1'b1, 1'b0, -1);

        // Partial frame, then the clock stays high
        push_exp('{kind: 3, data: model_last_good});
        clock_bit(1'b0);
        for (int i = 0; i < 4; i++) clock_bit(1'(i & 1));
        ps2_data = 1'b1;
        wait_cycles(TMO + 100);
        check("busy_after_timeout", 32'(busy), 32'd0);
`ifdef PS2_RX_ERRCNT_EN
        check("err_count_three", 32'(err_count), 32'd3);
`endif
        send_frame(8'h08, 1'b0, 1'b1, -1);

        // Idle glitch must not start a frame; mid-frame glitch must not consume a bit
        glitch();
        wait_cycles(20);
        check("busy_after_idle_glitch", 32'(busy), 32'd0);
        send_frame(8'hF4, 1'b0, 1'b1, 2);

        // Abort after data bit 5; remaining bits arrive while disabled
        clock_bit(1'b0);
        for (int i = 0; i < 6; i++) clock_bit(1'(i & 1));
        check("busy_before_abort", 32'(busy), 32'd1);
        rx_enable = 1'b0;
        wait_cycles(2);
        check("busy_after_abort", 32'(busy), 32'd0);
        clock_bit(1'b0);
        clock_bit(1'b0);
        clock_bit(1'b0);
        clock_bit(1'b1);
        ps2_data = 1'b1;
        wait_cycles(HP);
        rx_enable = 1'b1;
        wait_cycles(TMO + 50);
        check("rx_data_after_abort", 32'(rx_data), 32'h08 ^ 32'hFC);

        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            logic       p, s;
            d = 8'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(0, 4) != 0);
            send_frame(d, p, s, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
        end

        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("rx_data_end", 32'(rx_data), 32'(model_last_good));
`ifdef PS2_RX_ERRCNT_EN
        check("err_count_end", 32'(err_count), 32'((model_errs > 255) ? 255 : model_errs));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
